// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, instruction field positions and the FIFO entry layout.
// Also holds the word-building helper used by the encoder (and its decoder counterpart).
// No ports: types, localparams and one pure function only.
package mips_pkg;

  localparam int         EXT_R_BIT   = 6;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [6:0] EXT_ILLEGAL = 7'h40;

  // Field bit ranges of a 32-bit MIPS word
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fifo_entry_t;

  // Builds the instruction word from an extended opcode plus operand fields.
  // Fields that a format does not use are simply not placed in the word.
  function automatic logic [31:0] encode_inst(
    input logic [6:0]  ext_op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [25:0] imm
  );
    logic [5:0] op;
    op = ext_op[5:0];
    if (!ext_op[EXT_R_BIT]) begin
      return {6'b0, rs, rt, rd, shamt, op};
    end else if (op == OP_J || op == OP_JAL) begin
      return {op, imm};
    end else begin
      return {op, rs, rt, imm[15:0]};
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-based full/empty and a registered "last popped" value.
// Ports: clk/rst_n, flush_i (sync clear), push_i/din_i, pop_i/dout_o, full_o, empty_o.
// dout_o is the head entry when non-empty, otherwise the most recently popped entry.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign dout_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        last_d   = mem_q[rd_ptr_q];
      end
      // Simultaneous push and pop leaves the count unchanged
      if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: it is only visible once written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/inst_encoder.sv
// Rebuilds 32-bit MIPS words from an extended opcode plus fields, tags each with a fetch address, buffers in a FIFO.
// Ports: clk/resetn/flush, in_* valid/ready field input, out_* valid/ready {inst, addr} output, sticky err_illegal.
// Latency one cycle into an empty FIFO; in_ready = !full from registers only; the illegal opcode is swallowed and flagged.
module inst_encoder
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_ext_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [25:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err_illegal
);

  logic [31:0] wr_addr_q, wr_addr_d;
  logic        err_q, err_d;
  logic        accept, illegal, push, pop;
  logic        fifo_full, fifo_empty;
  fifo_entry_t wr_entry, rd_entry;

  // Flush wins over both handshakes in the same cycle
  assign accept  = in_valid & in_ready & ~flush;
  assign illegal = (in_ext_op == EXT_ILLEGAL);
  assign push    = accept & ~illegal;
  assign pop     = out_valid & out_ready & ~flush;

  assign wr_entry.addr = wr_addr_q;
  assign wr_entry.inst = encode_inst(in_ext_op, in_rs, in_rt, in_rd, in_shamt, in_imm);

  always_comb begin
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    if (flush) begin
      wr_addr_d = BASE_ADDR;
    end else if (push) begin
      wr_addr_d = wr_addr_q + 32'd4;
    end
    if (accept && illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_addr_q <= BASE_ADDR;
      err_q     <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (wr_entry),
    .pop_i   (pop),
    .dout_o  (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready    = ~fifo_full;
  assign out_valid   = ~fifo_empty;
  assign out_inst    = rd_entry.inst;
  assign out_addr    = rd_entry.addr;
  assign err_illegal = err_q;

endmodule
